// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU request path: request FSM states, counter width
// and the illegal-operation check used when an instruction is accepted.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

    localparam int STALLCNT_W = 16;

    // A load and a store decoded together is not a legal instruction.
    function automatic logic illegal_op(input logic rd, input logic wr);
        return rd & wr;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Count enabled cycles, holding once the maximum is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/request_unit.sv
// Sequences instruction and data memory requests for a multicycle CPU,
// producing the PC-advance strobe, sticky halt/error flags and a stall count.
module request_unit
    import cpu_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DatRead,
    input  logic                  DatWrite,
    input  logic                  Halt,
    input  logic                  ihit,
    input  logic                  dhit,
    output logic                  imemREN,
    output logic                  dmemREN,
    output logic                  dmemWEN,
    output logic                  pcEn,
    output logic                  halt,
    output logic                  opErr,
    output logic [STALLCNT_W-1:0] stallCnt
);

    reqstate_t state_r;
    reqstate_t state_next_s;
    logic      op_wr_r;
    logic      op_wr_next_s;
    logic      pc_en_s;
    logic      err_set_s;
    logic      stall_en_s;
    logic      imem_ren_r;
    logic      dmem_ren_r;
    logic      dmem_wen_r;
    logic      halt_r;
    logic      op_err_r;

    // Next-state, operation latch and PC-advance decode.
    always_comb begin
        state_next_s = state_r;
        op_wr_next_s = op_wr_r;
        pc_en_s      = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            FETCH: begin
                if (ihit) begin
                    if (Halt) begin
                        state_next_s = HALTED;
                    end else if (DatRead || DatWrite) begin
                        // A conflicting load+store resolves to a store.
                        state_next_s = DATA;
                        op_wr_next_s = DatWrite;
                        err_set_s    = illegal_op(DatRead, DatWrite);
                    end else begin
                        pc_en_s = 1'b1;
                    end
                end else begin
                    state_next_s = FETCH;
                end
            end
            DATA: begin
                if (dhit) begin
                    pc_en_s      = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = DATA;
                end
            end
            HALTED: begin
                state_next_s = HALTED;
            end
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // State register; request outputs are registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= FETCH;
            op_wr_r    <= 1'b0;
            imem_ren_r <= 1'b1;
            dmem_ren_r <= 1'b0;
            dmem_wen_r <= 1'b0;
            halt_r     <= 1'b0;
            op_err_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            op_wr_r    <= op_wr_next_s;
            imem_ren_r <= (state_next_s == FETCH);
            dmem_ren_r <= (state_next_s == DATA) && !op_wr_next_s;
            dmem_wen_r <= (state_next_s == DATA) && op_wr_next_s;
            halt_r     <= (state_next_s == HALTED);
            op_err_r   <= op_err_r | err_set_s;
        end
    end

    assign stall_en_s = !pc_en_s && (state_r != HALTED);

    sat_counter #(
        .W (STALLCNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .en    (stall_en_s),
        .count (stallCnt)
    );

    // An instruction aborted by reset must not advance the PC.
    assign pcEn    = pc_en_s & ~RST;
    assign imemREN = imem_ren_r;
    assign dmemREN = dmem_ren_r;
    assign dmemWEN = dmem_wen_r;
    assign halt    = halt_r;
    assign opErr   = op_err_r;

endmodule

// File: tb/tb_request_unit.sv
// Directed scoreboard bench for request_unit: each step queues the expected
// output vector for the cycle and compares it at the falling edge.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DatRead, DatWrite, Halt, ihit, dhit;
    logic        imemREN, dmemREN, dmemWEN, pcEn, halt, opErr;
    logic [15:0] stallCnt;

    typedef struct packed {
        logic        imem;
        logic        dren;
        logic        dwen;
        logic        pcen;
        logic        hlt;
        logic        err;
        logic [15:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    request_unit dut (
        .CLK      (CLK),
        .RST      (RST),
        .DatRead  (DatRead),
        .DatWrite (DatWrite),
        .Halt     (Halt),
        .ihit     (ihit),
        .dhit     (dhit),
        .imemREN  (imemREN),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .pcEn     (pcEn),
        .halt     (halt),
        .opErr    (opErr),
        .stallCnt (stallCnt)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t mk(input logic imem, input logic dren, input logic dwen,
                                input logic pcen, input logic hlt, input logic err,
                                input logic [15:0] cnt);
        obs_t o;
        o.imem = imem; o.dren = dren; o.dwen = dwen;
        o.pcen = pcen; o.hlt = hlt;   o.err = err; o.cnt = cnt;
        return o;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive(input logic r, input logic i, input logic d,
                         input logic rd, input logic wr, input logic h);
        RST = r; ihit = i; dhit = d; DatRead = rd; DatWrite = wr; Halt = h;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        RST = 1'b0;
    endtask

    task automatic step(input string tag, input logic r, input logic i, input logic d,
                        input logic rd, input logic wr, input logic h, input obs_t e);
        obs_t got;
        obs_t want;
        drive(r, i, d, rd, wr, h);
        exp_q.push_back(e);
        @(negedge CLK);
        got  = {imemREN, dmemREN, dmemWEN, pcEn, halt, opErr, stallCnt};
        want = exp_q.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        RST = 1'b0;

        // Three plain instructions back to back, then an idle fetch.
        step("plain0", 0, 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 16'd0));
        step("plain1", 0, 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 16'd0));
        step("plain2", 0, 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 16'd0));
        step("fetch_wait", 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'd0));

        // Load with dhit after two wait cycles; ihit ignored in DATA.
        do_reset();
        step("load_accept", 0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'd0));
        step("load_wait1",  0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 16'd1));
        step("load_wait2",  0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 16'd2));
        step("load_dhit",   0, 1, 1, 0, 0, 0, mk(0, 1, 0, 1, 0, 0, 16'd3));
        step("load_done",   0, 0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'd3));

        // Load and store together: store only, sticky error.
        do_reset();
        step("err_accept", 0, 1, 0, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 16'd0));
        step("err_wen",    0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 1, 16'd1));
        step("err_dhit",   0, 0, 1, 0, 0, 0, mk(0, 0, 1, 1, 0, 1, 16'd2));
        step("err_sticky0", 0, 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 1, 16'd2));
        step("err_sticky1", 0, 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 1, 16'd2));

        // Halt beats a store; everything stays quiet and the count freezes.
        do_reset();
        step("halt_accept", 0, 1, 0, 0, 1, 1, mk(1, 0, 0, 0, 0, 0, 16'd0));
        for (int k = 0; k < 10; k++) begin
            step("halt_quiet", 0, 1, 1, k[0], 1, 1, mk(0, 0, 0, 0, 1, 0, 16'd1));
        end

        // Reset during a store aborts it without a PC advance.
        do_reset();
        step("wr_accept", 0, 1, 0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 16'd0));
        step("wr_wait",   0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 16'd1));
        step("wr_rst",    1, 1, 1, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 16'd2));
        step("wr_aborted", 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'd0));

        // Long ihit starvation: count reaches 0xFFFF and sticks there.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(65534);
        step("sat_edge", 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'hFFFE));
        step("sat_max",  0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'hFFFF));
        tick(5000);
        step("sat_hold", 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
